// File: rtl/fetch_ifq_pkg.sv
// Shared sizing defaults and entry types for the fetch instruction queue.
package fetch_ifq_pkg;

  localparam int IFQ_DEPTH   = 4;
  localparam int PC_WIDTH    = 39;
  localparam int FETCH_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_SENT = 2'd2,
    ST_DONE = 2'd3
  } ifq_state_e;

  typedef struct packed {
    ifq_state_e             state;
    logic                   kill;
    logic [PC_WIDTH-1:0]    pc;
    logic [FETCH_WIDTH-1:0] data;
    logic                   excp;
  } ifq_entry_t;

endpackage

// File: rtl/fetch_ifq_entry.sv
// One fetch queue slot: lifecycle state, kill bit and the line payload.
module fetch_ifq_entry
  import fetch_ifq_pkg::*;
#(
  parameter int PC_W   = PC_WIDTH,
  parameter int DATA_W = FETCH_WIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alloc_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              issue_i,
  input  logic              resp_i,
  input  logic [DATA_W-1:0] resp_data_i,
  input  logic              resp_excp_i,
  input  logic              flush_i,
  input  logic              free_i,
  output ifq_state_e        state_o,
  output logic              kill_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic              excp_o
);

  ifq_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              excp_q, excp_d;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    data_d  = data_q;
    excp_d  = excp_q;
    if (free_i) begin
      state_d = ST_FREE;
      kill_d  = 1'b0;
    end else begin
      if (alloc_i) begin
        state_d = ST_PEND;
        kill_d  = 1'b0;
        pc_d    = pc_i;
      end
      if (issue_i) begin
        state_d = ST_SENT;
      end
      // Responses only land on an entry that is actually waiting for one.
      if (resp_i && (state_q == ST_SENT)) begin
        state_d = ST_DONE;
        data_d  = resp_data_i;
        excp_d  = resp_excp_i;
      end
      if (flush_i && (state_q != ST_FREE)) begin
        kill_d = 1'b1;
      end
    end
  end

  // NOTE: the payload is reset as well, because the line data must read zero while in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FREE;
      kill_q  <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
      excp_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every entry samples the same pre-edge values.
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      excp_q  <= excp_d;
    end
  end

  assign state_o = state_q;
  assign kill_o  = kill_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;
  assign excp_o  = excp_q;

endmodule

// File: rtl/fetch_ifq.sv
// Fetch instruction queue: in-order issue to the I$, out-of-order fill, in-order delivery.
module fetch_ifq #(
  parameter int IFQ_DEPTH   = fetch_ifq_pkg::IFQ_DEPTH,
  parameter int PC_WIDTH    = fetch_ifq_pkg::PC_WIDTH,
  parameter int FETCH_WIDTH = fetch_ifq_pkg::FETCH_WIDTH,
  parameter int TAG_W       = $clog2(IFQ_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush_i,
  input  logic                   req_vld_i,
  output logic                   req_rdy_o,
  input  logic [PC_WIDTH-1:0]    req_pc_i,
  output logic                   fetch_l1i_if_req_vld_o,
  input  logic                   fetch_l1i_if_req_rdy_i,
  output logic [TAG_W-1:0]       fetch_l1i_if_req_if_tag_o,
  output logic [PC_WIDTH-1:0]    fetch_l1i_if_req_pc_o,
  input  logic                   l1i_fetch_if_resp_vld_i,
  input  logic [TAG_W-1:0]       l1i_fetch_if_resp_if_tag_i,
  input  logic [FETCH_WIDTH-1:0] l1i_fetch_if_resp_data_i,
  input  logic                   l1i_fetch_if_resp_excp_i,
  output logic                   out_vld_o,
  input  logic                   out_rdy_i,
  output logic [PC_WIDTH-1:0]    out_pc_o,
  output logic [FETCH_WIDTH-1:0] out_data_o,
  output logic                   out_excp_o,
  output logic [TAG_W:0]         occupancy_o
);
  import fetch_ifq_pkg::*;

  localparam int OCC_W = TAG_W + 1;

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, issue_q, issue_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  ifq_state_e             ent_state [IFQ_DEPTH];
  logic                   ent_kill  [IFQ_DEPTH];
  logic [PC_WIDTH-1:0]    ent_pc    [IFQ_DEPTH];
  logic [FETCH_WIDTH-1:0] ent_data  [IFQ_DEPTH];
  logic                   ent_excp  [IFQ_DEPTH];

  logic full, enq, issue_hs, out_hs, auto_free, deq;

  // Ready depends only on registered occupancy, never on the output side this cycle.
  assign full      = (occ_q == OCC_W'(IFQ_DEPTH));
  assign req_rdy_o = !full && !flush_i;
  assign enq       = req_vld_i && req_rdy_o;

  assign fetch_l1i_if_req_vld_o    = (ent_state[issue_q] == ST_PEND) && !ent_kill[issue_q] && !flush_i;
  assign issue_hs                  = fetch_l1i_if_req_vld_o && fetch_l1i_if_req_rdy_i;
  assign fetch_l1i_if_req_if_tag_o = issue_q;
  assign fetch_l1i_if_req_pc_o     = ent_pc[issue_q];

  assign out_vld_o  = (ent_state[head_q] == ST_DONE) && !ent_kill[head_q] && !flush_i;
  assign out_hs     = out_vld_o && out_rdy_i;
  assign out_pc_o   = ent_pc[head_q];
  assign out_data_o = ent_data[head_q];
  assign out_excp_o = ent_excp[head_q];

  // A killed head retires on its own unless its I$ response is still outstanding.
  assign auto_free = ent_kill[head_q] && (ent_state[head_q] != ST_FREE) &&
                     (ent_state[head_q] != ST_SENT);
  assign deq       = out_hs || auto_free;

  always_comb begin
    head_d  = head_q + TAG_W'(deq);
    tail_d  = tail_q + TAG_W'(enq);
    issue_d = flush_i ? tail_q : (issue_q + TAG_W'(issue_hs));
    occ_d   = occ_q + OCC_W'(enq) - OCC_W'(deq);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      issue_q <= '0;
      occ_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      issue_q <= issue_d;
      occ_q   <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

  for (genvar i = 0; i < IFQ_DEPTH; i++) begin : g_entry
    fetch_ifq_entry #(
      .PC_W   (PC_WIDTH),
      .DATA_W (FETCH_WIDTH)
    ) u_entry (
      .clk         (clk),
      .rstn        (rstn),
      .alloc_i     (enq && (tail_q == TAG_W'(i))),
      .pc_i        (req_pc_i),
      .issue_i     (issue_hs && (issue_q == TAG_W'(i))),
      .resp_i      (l1i_fetch_if_resp_vld_i && (l1i_fetch_if_resp_if_tag_i == TAG_W'(i))),
      .resp_data_i (l1i_fetch_if_resp_data_i),
      .resp_excp_i (l1i_fetch_if_resp_excp_i),
      .flush_i     (flush_i),
      .free_i      (deq && (head_q == TAG_W'(i))),
      .state_o     (ent_state[i]),
      .kill_o      (ent_kill[i]),
      .pc_o        (ent_pc[i]),
      .data_o      (ent_data[i]),
      .excp_o      (ent_excp[i])
    );
  end

endmodule

// File: tb/tb_fetch_ifq.sv
// Directed scenarios plus randomized traffic against an in-order line scoreboard.
module tb_fetch_ifq;
  import fetch_ifq_pkg::*;

  localparam int DEPTH = 4;
  localparam int PCW   = 39;
  localparam int DW    = 128;
  localparam int TW    = 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           flush, req_vld, req_rdy;
  logic [PCW-1:0] req_pc;
  logic           f_vld, f_rdy;
  logic [TW-1:0]  f_tag;
  logic [PCW-1:0] f_pc;
  logic           r_vld, r_excp;
  logic [TW-1:0]  r_tag;
  logic [DW-1:0]  r_data;
  logic           o_vld, o_rdy, o_excp;
  logic [PCW-1:0] o_pc;
  logic [DW-1:0]  o_data;
  logic [TW:0]    occ;

  int n_cmp = 0;
  int n_err = 0;
  int order [4] = '{3, 1, 0, 2};

  always #5 clk = ~clk;

  fetch_ifq u_dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .flush_i                    (flush),
    .req_vld_i                  (req_vld),
    .req_rdy_o                  (req_rdy),
    .req_pc_i                   (req_pc),
    .fetch_l1i_if_req_vld_o     (f_vld),
    .fetch_l1i_if_req_rdy_i     (f_rdy),
    .fetch_l1i_if_req_if_tag_o  (f_tag),
    .fetch_l1i_if_req_pc_o      (f_pc),
    .l1i_fetch_if_resp_vld_i    (r_vld),
    .l1i_fetch_if_resp_if_tag_i (r_tag),
    .l1i_fetch_if_resp_data_i   (r_data),
    .l1i_fetch_if_resp_excp_i   (r_excp),
    .out_vld_o                  (o_vld),
    .out_rdy_i                  (o_rdy),
    .out_pc_o                   (o_pc),
    .out_data_o                 (o_data),
    .out_excp_o                 (o_excp),
    .occupancy_o                (occ)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int t);
    return {4{32'(32'hC0DE_0000 + t)}};
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; req_vld = 1'b0; req_pc = '0; f_rdy = 1'b0;
    r_vld = 1'b0; r_tag = '0; r_data = '0; r_excp = 1'b0; o_rdy = 1'b0;
  endtask

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rstn = 1'b0;
    to_check();
    check("rst_req_rdy", req_rdy, 1);
    check("rst_out_vld", o_vld, 0);
    check("rst_issue_vld", f_vld, 0);
    check("rst_occ", occ, 0);
    check("rst_out_pc", o_pc, 0);
    check("rst_out_data", o_data, 0);
    check("rst_issue_tag", f_tag, 0);
    to_drive();
    rstn = 1'b1;
  endtask

  // Responses to entries that are not SENT are ignored, so sweeping all tags drains safely.
  task automatic drain(input string tag);
    int cyc = 0;
    while (occ != 0 && cyc < 100) begin
      to_drive();
      req_vld = 1'b0; flush = 1'b0; f_rdy = 1'b1; o_rdy = 1'b1;
      r_vld = 1'b1; r_tag = TW'(cyc); r_data = '0; r_excp = 1'b0;
      to_check();
      cyc++;
    end
    check(tag, occ, 0);
    to_drive();
    idle_inputs();
  endtask

  // Random-phase scoreboard
  ifq_entry_t     exp_out [$];
  logic [PCW-1:0] exp_issue [$];
  bit             os_vld  [DEPTH];
  bit             os_live [DEPTH];
  logic [PCW-1:0] os_pc   [DEPTH];

  initial begin
    idle_inputs();

    // In-order delivery with out-of-order responses 3,1,0,2
    do_reset();
    for (int k = 0; k < 5; k++) begin
      to_drive();
      f_rdy = 1'b1; o_rdy = 1'b1;
      req_vld = (k < 4); req_pc = 39'h1000 + PCW'(16 * k);
      to_check();
      if (k < 4) check("s1_req_rdy", req_rdy, 1);
      check("s1_issue_vld", f_vld, (k >= 1));
      if (k >= 1) begin
        check("s1_issue_tag", f_tag, k - 1);
        check("s1_issue_pc", f_pc, 39'h1000 + PCW'(16 * (k - 1)));
      end
    end
    for (int k = 0; k < 8; k++) begin
      to_drive();
      req_vld = 1'b0;
      r_vld = (k < 4);
      if (k < 4) begin
        r_tag = TW'(order[k]); r_data = mk_data(order[k]); r_excp = 1'b0;
      end
      to_check();
      if (k >= 3 && k <= 6) begin
        check("s1_out_vld", o_vld, 1);
        check("s1_out_pc", o_pc, 39'h1000 + PCW'(16 * (k - 3)));
        check("s1_out_data", o_data, mk_data(k - 3));
        check("s1_out_excp", o_excp, 0);
      end else begin
        check("s1_out_idle", o_vld, 0);
      end
    end
    check("s1_occ_empty", occ, 0);

    // Full queue backpressure
    do_reset();
    for (int k = 0; k < 4; k++) begin
      to_drive();
      req_vld = 1'b1; req_pc = 39'h3000 + PCW'(16 * k); f_rdy = 1'b1; o_rdy = 1'b0;
      to_check();
      check("s2_fill_rdy", req_rdy, 1);
    end
    to_drive(); req_pc = 39'h3040; to_check();
    check("s2_full_rdy", req_rdy, 0);
    check("s2_full_occ", occ, 4);
    to_drive(); r_vld = 1'b1; r_tag = 0; r_data = mk_data(0); to_check();
    check("s2_still_full", req_rdy, 0);
    to_drive(); r_vld = 1'b0; o_rdy = 1'b1; to_check();
    check("s2_out_vld", o_vld, 1);
    check("s2_out_pc", o_pc, 39'h3000);
    check("s2_rdy_not_comb", req_rdy, 0);
    to_drive(); o_rdy = 1'b0; to_check();
    check("s2_rdy_after_deq", req_rdy, 1);
    check("s2_occ_after_deq", occ, 3);
    to_drive(); req_vld = 1'b0; to_check();
    check("s2_occ_refill", occ, 4);
    drain("s2_drain");

    // Flush with two lines in flight, then a new request
    do_reset();
    to_drive(); f_rdy = 1'b1; o_rdy = 1'b1; req_vld = 1'b1; req_pc = 39'h5000; to_check();
    to_drive(); req_pc = 39'h5010; to_check();
    check("s3_issue0_tag", f_tag, 0);
    to_drive(); req_vld = 1'b0; to_check();
    check("s3_issue1_tag", f_tag, 1);
    to_drive(); flush = 1'b1; to_check();
    check("s3_flush_rdy", req_rdy, 0);
    check("s3_flush_issue", f_vld, 0);
    check("s3_flush_out", o_vld, 0);
    to_drive(); flush = 1'b0; req_vld = 1'b1; req_pc = 39'h8000; to_check();
    check("s3_post_rdy", req_rdy, 1);
    check("s3_post_occ", occ, 2);
    to_drive(); req_vld = 1'b0; to_check();
    check("s3_new_issue", f_vld, 1);
    check("s3_new_tag", f_tag, 2);
    check("s3_new_pc", f_pc, 39'h8000);
    for (int k = 0; k < 5; k++) begin
      to_drive();
      f_rdy = 1'b0;
      r_vld = (k < 3);
      r_tag = (k == 0) ? TW'(2) : (k == 1) ? TW'(0) : TW'(1);
      r_data = mk_data(int'(r_tag));
      to_check();
      check("s3_out_vld", o_vld, (k == 4));
      if (k == 4) begin
        check("s3_out_pc", o_pc, 39'h8000);
        check("s3_out_data", o_data, mk_data(2));
      end
    end
    drain("s3_drain");

    // Response coincident with flush
    do_reset();
    to_drive(); f_rdy = 1'b1; o_rdy = 1'b1; req_vld = 1'b1; req_pc = 39'h6000; to_check();
    to_drive(); req_vld = 1'b0; to_check();
    check("s4_issue_tag", f_tag, 0);
    to_drive(); flush = 1'b1; r_vld = 1'b1; r_tag = 0; r_data = mk_data(0); to_check();
    check("s4_flush_out", o_vld, 0);
    to_drive(); flush = 1'b0; r_vld = 1'b0; to_check();
    check("s4_killed_out", o_vld, 0);
    check("s4_killed_occ", occ, 1);
    to_drive(); to_check();
    check("s4_freed_out", o_vld, 0);
    check("s4_freed_occ", occ, 0);

    // Exception line, responses to non-SENT entries
    do_reset();
    to_drive(); f_rdy = 1'b0; o_rdy = 1'b1; req_vld = 1'b1; req_pc = 39'h2000; to_check();
    to_drive(); req_vld = 1'b0; r_vld = 1'b1; r_tag = 0; r_excp = 1'b0; r_data = mk_data(9); to_check();
    to_drive(); r_vld = 1'b0; f_rdy = 1'b1; to_check();
    check("s5_pend_resp_out", o_vld, 0);
    check("s5_pend_still_issue", f_vld, 1);
    to_drive(); f_rdy = 1'b0; r_vld = 1'b1; r_tag = 0; r_excp = 1'b1; r_data = mk_data(7); to_check();
    check("s5_pre_out", o_vld, 0);
    to_drive(); r_vld = 1'b0; to_check();
    check("s5_out_vld", o_vld, 1);
    check("s5_out_pc", o_pc, 39'h2000);
    check("s5_out_excp", o_excp, 1);
    check("s5_out_data", o_data, mk_data(7));
    to_drive(); r_vld = 1'b1; r_tag = 1; r_excp = 1'b0; to_check();
    check("s5_free_resp_occ", occ, 0);
    to_drive(); r_vld = 1'b0; to_check();
    check("s5_free_resp_out", o_vld, 0);
    check("s5_free_resp_occ2", occ, 0);

    // Asynchronous reset with lines in flight
    do_reset();
    for (int k = 0; k < 5; k++) begin
      to_drive(); f_rdy = 1'b1; o_rdy = 1'b0; req_vld = (k < 4); req_pc = 39'h7000 + PCW'(16 * k);
      to_check();
    end
    to_drive(); f_rdy = 1'b0; r_vld = 1'b1; r_tag = 0; r_data = mk_data(0); to_check();
    to_drive(); r_vld = 1'b0; to_check();
    check("s6_pre_out", o_vld, 1);
    check("s6_pre_occ", occ, 4);
    #2 rstn = 1'b0;
    #1;
    check("s6_async_out", o_vld, 0);
    check("s6_async_occ", occ, 0);
    check("s6_async_rdy", req_rdy, 1);
    check("s6_async_pc", o_pc, 0);
    check("s6_async_data", o_data, 0);
    to_drive(); rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      to_drive(); o_rdy = 1'b1; r_vld = 1'b1; r_tag = TW'(k); r_data = mk_data(k); to_check();
      check("s6_late_occ", occ, 0);
    end
    to_drive(); r_vld = 1'b0; to_check();
    check("s6_late_out", o_vld, 0);

    // Randomized traffic against the in-order scoreboard
    do_reset();
    begin : rnd
      logic [PCW-1:0] next_pc;
      logic [PCW-1:0] pexp;
      bit             done, drain_mode, resp_real, any_os;
      int             c, cand [$];
      ifq_entry_t     front;
      next_pc = 39'h10000;
      done = 1'b0;
      c = 0;
      for (int t = 0; t < DEPTH; t++) begin
        os_vld[t] = 1'b0; os_live[t] = 1'b0; os_pc[t] = '0;
      end
      while (!done) begin
        drain_mode = (c >= 3000);
        to_drive();
        if (!drain_mode) begin
          flush   = ($urandom_range(0, 39) == 0);
          req_vld = ($urandom_range(0, 2) != 0);
          f_rdy   = ($urandom_range(0, 3) != 0);
          o_rdy   = ($urandom_range(0, 2) != 0);
        end else begin
          flush = 1'b0; req_vld = 1'b0; f_rdy = 1'b1; o_rdy = 1'b1;
        end
        req_pc = next_pc;
        cand.delete();
        for (int t = 0; t < DEPTH; t++) if (os_vld[t]) cand.push_back(t);
        r_vld = 1'b0;
        r_tag = TW'($urandom_range(0, DEPTH - 1));
        if (cand.size() > 0 && (drain_mode || $urandom_range(0, 2) == 0)) begin
          r_vld = 1'b1;
          r_tag = TW'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 15) == 0) begin
          r_vld = !os_vld[r_tag];
        end
        r_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        r_excp = ($urandom_range(0, 7) == 0);
        resp_real = r_vld && os_vld[r_tag];

        to_check();
        check("rnd_req_rdy", req_rdy, (occ != 3'(DEPTH)) && !flush);
        if (flush) begin
          check("rnd_flush_issue", f_vld, 0);
          check("rnd_flush_out", o_vld, 0);
        end
        if (o_vld && o_rdy) begin
          if (exp_out.size() == 0) begin
            check("rnd_out_spurious", o_vld, 0);
          end else begin
            front = exp_out.pop_front();
            if (front.state != ST_DONE) begin
              check("rnd_out_early", o_vld, 0);
            end else begin
              check("rnd_out_pc", o_pc, front.pc);
              check("rnd_out_data", o_data, front.data);
              check("rnd_out_excp", o_excp, front.excp);
            end
          end
        end
        if (f_vld && f_rdy) begin
          check("rnd_tag_reuse", os_vld[f_tag], 0);
          if (exp_issue.size() == 0) begin
            check("rnd_issue_spurious", f_vld, 0);
          end else begin
            pexp = exp_issue.pop_front();
            check("rnd_issue_pc", f_pc, pexp);
            os_vld[f_tag] = 1'b1; os_live[f_tag] = 1'b1; os_pc[f_tag] = pexp;
          end
        end
        if (resp_real) begin
          if (os_live[r_tag] && !flush) begin
            foreach (exp_out[i]) begin
              if (exp_out[i].pc == os_pc[r_tag]) begin
                exp_out[i].state = ST_DONE;
                exp_out[i].data  = r_data;
                exp_out[i].excp  = r_excp;
              end
            end
          end
          os_vld[r_tag] = 1'b0;
        end
        if (req_vld && req_rdy) begin
          exp_issue.push_back(req_pc);
          exp_out.push_back('{state: ST_PEND, kill: 1'b0, pc: req_pc, data: '0, excp: 1'b0});
          next_pc = next_pc + PCW'(16);
        end
        if (flush) begin
          exp_issue.delete();
          exp_out.delete();
          for (int t = 0; t < DEPTH; t++) os_live[t] = 1'b0;
        end
        c++;
        any_os = 1'b0;
        for (int t = 0; t < DEPTH; t++) any_os = any_os | os_vld[t];
        if (drain_mode && exp_out.size() == 0 && !any_os && occ == 0) done = 1'b1;
        if (c >= 3500) done = 1'b1;
      end
      check("rnd_drain_occ", occ, 0);
      check("rnd_drain_left", exp_out.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
